// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared funct3 codes, FSM encoding and latency counter width for the data memory unit
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // WAIT counts down from RD_LATENCY-2, so the widest count is MAX_RD_LATENCY-2.
    localparam int MAX_RD_LATENCY = 4;
    localparam int LAT_CNT_W      = $clog2(MAX_RD_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_unit_if.sv
// rtl/data_memory_unit_if.sv - request/response bundle between the core load/store path and the data memory
interface data_memory_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Decode size/sign: replicate store data across lanes so the enables pick the right bytes.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
                misaligned = (addr_lo != 2'b00);
            end
            F3_BU: begin
                rdata_ext  = {24'h0, byte_sel};
                illegal    = we;
            end
            F3_HU: begin
                rdata_ext  = {16'h0, half_sel};
                misaligned = addr_lo[0];
                illegal    = we;
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - RV32I data memory with valid/ready request and fixed-latency response
module data_memory_unit
    import rv_mem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    data_memory_unit_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 state, next_state;
    logic [LAT_CNT_W-1:0]   cnt, next_cnt;
    logic [31:0]            mem [DEPTH];
    logic [31:0]            cap_rdata;
    logic                   cap_fault;
    logic [31:0]            rsp_rdata_q;
    logic                   rsp_fault_q;
    logic                   ready;
    logic                   accept;
    logic                   out_of_range;
    logic                   misaligned;
    logic                   illegal;
    logic                   fault;
    logic                   do_write;
    logic [AW-1:0]          widx;
    logic [3:0]             byte_en;
    logic [31:0]            wdata_lane;
    logic [31:0]            rword;
    logic [31:0]            rdata_ext;
    logic [31:0]            result;

    assign ready         = (state == ST_IDLE) || (state == ST_RESP);
    assign accept        = bus.req_valid && ready;
    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;

    assign widx         = bus.req_addr[AW+1:2];
    assign out_of_range = (bus.req_addr[31:2] >= 30'(DEPTH));
    assign rword        = mem[widx];

    mem_lane_align u_align (
        .we         (bus.req_we),
        .funct3     (bus.req_funct3),
        .addr_lo    (bus.req_addr[1:0]),
        .wdata      (bus.req_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign fault    = out_of_range || misaligned || illegal;
    assign do_write = accept && bus.req_we && !fault;
    assign result   = (fault || bus.req_we) ? 32'h0 : rdata_ext;

    // Byte-granular store at the accepting edge; faulted accesses never touch the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= 32'h0;
            end
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[widx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state: RESP doubles as an accept slot so back-to-back requests lose no cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (RD_LATENCY == 1) begin
                        next_state = ST_RESP;
                    end else begin
                        next_state = ST_WAIT;
                        next_cnt   = LAT_CNT_W'(RD_LATENCY - 2);
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    next_state = ST_RESP;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the already-aligned result at accept so later stores cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_rdata <= 32'h0;
            cap_fault <= 1'b0;
        end else if (accept) begin
            cap_rdata <= result;
            cap_fault <= fault;
        end
    end

    // Response registers change only on entry to RESP and hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else if (next_state == ST_RESP) begin
            rsp_rdata_q <= accept ? result : cap_rdata;
            rsp_fault_q <= accept ? fault  : cap_fault;
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - directed self-checking bench for data_memory_unit at RD_LATENCY 1..4
module tb_data_memory_unit;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        reset_n;
    logic [3:0]  drv_valid;
    logic [3:0]  drv_we;
    logic [2:0]  drv_f3    [4];
    logic [31:0] drv_addr  [4];
    logic [31:0] drv_wdata [4];
    logic [3:0]  mon_ready;
    logic [3:0]  mon_rvalid;
    logic [3:0]  mon_fault;
    logic [31:0] mon_rdata [4];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_memory_unit_if bus ();
        assign bus.req_valid  = drv_valid[g];
        assign bus.req_we     = drv_we[g];
        assign bus.req_funct3 = drv_f3[g];
        assign bus.req_addr   = drv_addr[g];
        assign bus.req_wdata  = drv_wdata[g];
        assign mon_ready[g]   = bus.req_ready;
        assign mon_rvalid[g]  = bus.rsp_valid;
        assign mon_fault[g]   = bus.rsp_fault;
        assign mon_rdata[g]   = bus.rsp_rdata;
        data_memory_unit #(.DEPTH(64), .RD_LATENCY(g + 1)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input int i, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!mon_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", n, 0);
        drv_valid[i] = 1'b1;
        drv_we[i]    = w;
        drv_f3[i]    = f3;
        drv_addr[i]  = a;
        drv_wdata[i] = d;
        @(negedge clk);
        drv_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output int n);
        n = 1;
        while (!mon_rvalid[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic xfer(input int i, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic flt);
        int n;
        issue(i, w, f3, a, d);
        wait_rsp(i, n);
        check("latency", n, i + 1);
        rd  = mon_rdata[i];
        flt = mon_fault[i];
    endtask

    task automatic ld_check(input int i, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp_d, input logic exp_f, input string tag);
        logic [31:0] rd;
        logic        flt;
        xfer(i, 1'b0, f3, a, 32'h0, rd, flt);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_f});
    endtask

    task automatic st_check(input int i, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic exp_f, input string tag);
        logic [31:0] rd;
        logic        flt;
        xfer(i, 1'b1, f3, a, d, rd, flt);
        check({tag, "_data"}, rd, 32'h0);
        check({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_f});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int          n;
        int          seen;
        int          pulses;
        int          low;
        int          acc;
        int          expt;
        int          exp_q[$];
        reset_n   = 1'b0;
        drv_valid = '0;
        drv_we    = '0;
        for (int k = 0; k < 4; k++) begin
            drv_f3[k]    = 3'b000;
            drv_addr[k]  = 32'h0;
            drv_wdata[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready",  {28'b0, mon_ready},  32'hF);
        check("reset_rvalid", {28'b0, mon_rvalid}, 32'h0);
        check("reset_fault",  {28'b0, mon_fault},  32'h0);
        check("reset_rdata2", mon_rdata[2], 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of WAIT at RD_LATENCY=3
        st_check(2, W, 32'h0, 32'h1234_5678, 1'b0, "pre_sw0");
        ld_check(2, W, 32'h0, 32'h1234_5678, 1'b0, "pre_lw0");
        issue(2, 1'b0, W, 32'h0, 32'h0);
        check("mid_wait_ready", {31'b0, mon_ready[2]}, 32'h0);
        reset_n = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | int'(mon_rvalid[2]);
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen = seen | int'(mon_rvalid[2]);
        end
        check("abort_no_rsp", seen, 0);
        check("abort_ready", {31'b0, mon_ready[2]}, 32'h1);
        ld_check(2, W, 32'h0, 32'h0, 1'b0, "abort_word0");

        // Load extension
        st_check(2, W,  32'h10, 32'h8000_00F1, 1'b0, "sw_10");
        ld_check(2, B,  32'h10, 32'hFFFF_FFF1, 1'b0, "lb_10");
        ld_check(2, BU, 32'h10, 32'h0000_00F1, 1'b0, "lbu_10");
        ld_check(2, H,  32'h10, 32'h0000_00F1, 1'b0, "lh_10");
        ld_check(2, HU, 32'h10, 32'h0000_00F1, 1'b0, "lhu_10");
        ld_check(2, W,  32'h10, 32'h8000_00F1, 1'b0, "lw_10");
        repeat (2) @(negedge clk);
        check("hold_rvalid", {31'b0, mon_rvalid[2]}, 32'h0);
        check("hold_rdata", mon_rdata[2], 32'h8000_00F1);

        // Partial stores merge into the word
        st_check(2, W, 32'h20, 32'h1122_3344, 1'b0, "sw_20");
        st_check(2, B, 32'h23, 32'h0000_00AA, 1'b0, "sb_23");
        st_check(2, H, 32'h20, 32'h0000_BEEF, 1'b0, "sh_20");
        ld_check(2, W,  32'h20, 32'hAA22_BEEF, 1'b0, "lw_20");
        ld_check(2, H,  32'h22, 32'hFFFF_AA22, 1'b0, "lh_22");
        ld_check(2, BU, 32'h23, 32'h0000_00AA, 1'b0, "lbu_23");

        // Faults suppress the access and return zero data
        ld_check(2, H,      32'h21,  32'h0, 1'b1, "f_lh_21");
        st_check(2, W,      32'h22,  32'hDEAD_BEEF, 1'b1, "f_sw_22");
        ld_check(2, W,      32'h100, 32'h0, 1'b1, "f_lw_100");
        ld_check(2, 3'b011, 32'h20,  32'h0, 1'b1, "f_ld_011");
        st_check(2, BU,     32'h20,  32'h55, 1'b1, "f_st_100");
        st_check(2, W,      32'h100, 32'hFFFF_FFFF, 1'b1, "f_sw_100");
        ld_check(2, W,      32'h20,  32'hAA22_BEEF, 1'b0, "f_unchanged_20");
        ld_check(2, W,      32'h0,   32'h0, 1'b0, "f_unchanged_0");
        ld_check(2, W,      32'hFC,  32'h0, 1'b0, "top_word");

        // Back-to-back throughput sweep, req_valid held for 10 accepts
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv_we[i]   = 1'b0;
            drv_f3[i]   = W;
            drv_addr[i] = 32'h40;
            pulses = 0;
            low    = 0;
            acc    = 0;
            exp_q.delete();
            for (int c = 0; c < 60; c++) begin
                if (c > 0) @(negedge clk);
                if (mon_rvalid[i]) begin
                    pulses++;
                    expt = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check("sweep_time", c, expt);
                end
                if (!mon_ready[i]) low++;
                drv_valid[i] = (acc < 10);
                if (drv_valid[i] && mon_ready[i]) begin
                    exp_q.push_back(c + i + 1);
                    acc++;
                end
            end
            drv_valid[i] = 1'b0;
            check("sweep_pulses", pulses, 10);
            check("sweep_ready_low", low, 10 * i);
            check("sweep_pending", exp_q.size(), 0);
        end

        // Load accepted in the RESP cycle of a store to the same word
        for (int i = 0; i < 4; i += 2) begin
            @(negedge clk);
            issue(i, 1'b1, W, 32'h30, 32'hCAFE_F00D + i);
            wait_rsp(i, n);
            check("raw_st_lat", n, i + 1);
            check("raw_st_fault", {31'b0, mon_fault[i]}, 32'h0);
            issue(i, 1'b0, W, 32'h30, 32'h0);
            wait_rsp(i, n);
            check("raw_ld_lat", n, i + 1);
            check("raw_ld_data", mon_rdata[i], 32'hCAFE_F00D + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
